// File: rtl/regs_pkg.sv
// Shared types for the register-file writeback arbiter: index type, zero register, source enum.
package regs_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  typedef logic [REG_AW-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

  // Round-robin pointer value names the source that currently holds priority.
  typedef enum logic {
    SRC_A = 1'b0,
    SRC_L = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regs_writeback_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: bit 0 is the ALU source, bit 1 the load-return source.
module rr_arbiter2
  import regs_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] eligible,
  output logic [1:0] grant
);

  wb_src_e ptr_q;
  wb_src_e ptr_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= SRC_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Priority passes to the other source after every grant; idle cycles leave it alone.
  always_comb begin
    grant = 2'b00;
    ptr_d = ptr_q;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (ptr_q == SRC_A) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    if (grant[0]) begin
      ptr_d = SRC_L;
    end else if (grant[1]) begin
      ptr_d = SRC_A;
    end
  end

endmodule

// File: rtl/regs_writeback_arbiter.sv
// Shares the register-file write port between ALU and load-return writebacks and keeps a
// per-register busy scoreboard of outstanding loads for read-after-load stalls.
module regs_writeback_arbiter
  import regs_pkg::*;
#(
  parameter int AddressBitWidth = REG_AW,
  parameter int DataBitWidth    = REG_DW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [AddressBitWidth-1:0] a_rd,
  input  logic [DataBitWidth-1:0]    a_wd,
  input  logic                       l_valid,
  output logic                       l_ready,
  input  logic [AddressBitWidth-1:0] l_rd,
  input  logic [DataBitWidth-1:0]    l_wd,
  input  logic                       ld_issue,
  output logic                       ld_issue_ready,
  input  logic [AddressBitWidth-1:0] ld_issue_rd,
  input  logic [AddressBitWidth-1:0] rs1,
  input  logic [AddressBitWidth-1:0] rs2,
  output logic                       rs1_busy,
  output logic                       rs2_busy,
  output logic [AddressBitWidth-1:0] rd,
  output logic                       rd_we,
  output logic [DataBitWidth-1:0]    rd_wd
);

  localparam int NumRegs = 2 ** AddressBitWidth;

  // Handshake: a source transfers on a cycle where valid & ready are both high; while
  // valid & !ready the requester holds its rd/wd stable. Ready is combinational.

  logic [NumRegs-1:0] busy_q;
  logic [NumRegs-1:0] busy_d;
  logic [1:0]         eligible;
  logic [1:0]         grant;
  logic               issue_set;

  // Busy bit 0 is never set, so x0 reads and issues see it as free.
  assign eligible[0] = rst_n & a_valid & ~busy_q[a_rd];
  assign eligible[1] = rst_n & l_valid;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .eligible (eligible),
    .grant    (grant)
  );

  assign a_ready = grant[0];
  assign l_ready = grant[1];

  assign ld_issue_ready = rst_n & ((ld_issue_rd == '0) | ~busy_q[ld_issue_rd]);
  assign issue_set      = ld_issue & ld_issue_ready & (ld_issue_rd != '0);

  assign rs1_busy = (rs1 != '0) & busy_q[rs1];
  assign rs2_busy = (rs2 != '0) & busy_q[rs2];

  // Clear applied before set so a load issued as the previous one retires keeps the bit.
  always_comb begin
    busy_d = busy_q;
    if (grant[1]) begin
      busy_d[l_rd] = 1'b0;
    end
    if (issue_set) begin
      busy_d[ld_issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Write port register; x0 grants complete the handshake but leave the port idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd    <= '0;
      rd_we <= 1'b0;
      rd_wd <= '0;
    end else begin
      rd_we <= 1'b0;
      if (grant[0] && (a_rd != '0)) begin
        rd    <= a_rd;
        rd_wd <= a_wd;
        rd_we <= 1'b1;
      end else if (grant[1] && (l_rd != '0)) begin
        rd    <= l_rd;
        rd_wd <= l_wd;
        rd_we <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regs_writeback_arbiter.sv
// Directed bench for regs_writeback_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_regs_writeback_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_rd;
  logic [31:0] a_wd;
  logic        l_valid;
  logic        l_ready;
  logic [4:0]  l_rd;
  logic [31:0] l_wd;
  logic        ld_issue;
  logic        ld_issue_ready;
  logic [4:0]  ld_issue_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [4:0]  rd;
  logic        rd_we;
  logic [31:0] rd_wd;

  regs_writeback_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .a_rd           (a_rd),
    .a_wd           (a_wd),
    .l_valid        (l_valid),
    .l_ready        (l_ready),
    .l_rd           (l_rd),
    .l_wd           (l_wd),
    .ld_issue       (ld_issue),
    .ld_issue_ready (ld_issue_ready),
    .ld_issue_rd    (ld_issue_rd),
    .rs1            (rs1),
    .rs2            (rs2),
    .rs1_busy       (rs1_busy),
    .rs2_busy       (rs2_busy),
    .rd             (rd),
    .rd_we          (rd_we),
    .rd_wd          (rd_wd)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] reg_model [32];

  typedef struct {
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_wd;
    logic        l_valid;
    logic [4:0]  l_rd;
    logic [31:0] l_wd;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        e_a_ready;
    logic        e_l_ready;
    logic        e_ldr;
    logic        e_rs1_busy;
    logic        e_rs2_busy;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic        chk_data;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (rd_we === 1'b1) reg_model[rd] = rd_wd;
  endtask

  task automatic drive_idle();
    a_valid = 0; a_rd = 0; a_wd = 0;
    l_valid = 0; l_rd = 0; l_wd = 0;
    ld_issue = 0; ld_issue_rd = 0;
    rs1 = 0; rs2 = 0;
  endtask

  task automatic drive_vec(input vec_t v);
    a_valid = v.a_valid; a_rd = v.a_rd; a_wd = v.a_wd;
    l_valid = v.l_valid; l_rd = v.l_rd; l_wd = v.l_wd;
    ld_issue = v.ld_issue; ld_issue_rd = v.ld_issue_rd;
    rs1 = v.rs1; rs2 = v.rs2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) reg_model[i] = '0;

    //                a_v  a_rd   a_wd           l_v  l_rd   l_wd        iss  iss_rd rs1    rs2    a_r  l_r  ldr  b1   b2   we   rd     wd             chk
    vecs[0]  = '{1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd0,  5'd0,  1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,5'd5,  32'hDEAD_BEEF, 1'b1};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd0,  5'd0,  1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,5'd5,  32'hDEAD_BEEF, 1'b1};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,     1'b1, 5'd7,  5'd0,  5'd0,  1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,5'd5,  32'hDEAD_BEEF, 1'b1};
    vecs[3]  = '{1'b1, 5'd7,  32'h2,         1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd7,  5'd0,  1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,5'd5,  32'hDEAD_BEEF, 1'b1};
    vecs[4]  = '{1'b1, 5'd7,  32'h2,         1'b0, 5'd0,  32'h0,     1'b0, 5'd7,  5'd7,  5'd7,  1'b0,1'b0,1'b0,1'b1,1'b1, 1'b0,5'd5,  32'hDEAD_BEEF, 1'b1};
    vecs[5]  = '{1'b1, 5'd7,  32'h2,         1'b1, 5'd7,  32'h1,     1'b0, 5'd0,  5'd7,  5'd0,  1'b0,1'b1,1'b1,1'b1,1'b0, 1'b1,5'd7,  32'h1,         1'b1};
    vecs[6]  = '{1'b1, 5'd7,  32'h2,         1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd7,  5'd0,  1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,5'd7,  32'h2,         1'b1};
    vecs[7]  = '{1'b1, 5'd0,  32'h55,        1'b0, 5'd0,  32'h0,     1'b1, 5'd0,  5'd0,  5'd0,  1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,5'd7,  32'h2,         1'b0};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  32'h66,    1'b1, 5'd0,  5'd0,  5'd0,  1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,5'd7,  32'h2,         1'b0};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd0,  5'd7,  1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,5'd7,  32'h2,         1'b1};
    vecs[10] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd12, 32'hC,     1'b0, 5'd0,  5'd0,  5'd0,  1'b0,1'b1,1'b1,1'b0,1'b0, 1'b1,5'd12, 32'hC,         1'b1};
    vecs[11] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd12, 5'd0,  1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,5'd12, 32'hC,         1'b1};

    // Reset held two cycles with an ALU request pending.
    drive_idle();
    rst_n = 1'b0;
    a_valid = 1'b1; a_rd = 5'd1; a_wd = 32'h11; rs1 = 5'd1;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("reset%0d rd_we", i), rd_we, 1'b0);
      check($sformatf("reset%0d rd", i), rd, 5'd0);
      check($sformatf("reset%0d rd_wd", i), rd_wd, 32'h0);
      check($sformatf("reset%0d a_ready", i), a_ready, 1'b0);
      check($sformatf("reset%0d ld_issue_ready", i), ld_issue_ready, 1'b0);
      check($sformatf("reset%0d rs1_busy", i), rs1_busy, 1'b0);
    end
    rst_n = 1'b1;
    step();
    check("post_reset a_ready", a_ready, 1'b1);
    step();
    check("post_reset rd_we", rd_we, 1'b1);
    check("post_reset rd", rd, 5'd1);
    check("post_reset rd_wd", rd_wd, 32'h11);

    // Table: comb outputs checked after drive, write port checked after the edge.
    for (int i = 0; i < 12; i++) begin
      drive_vec(vecs[i]);
      #1;
      check($sformatf("v%0d a_ready", i), a_ready, vecs[i].e_a_ready);
      check($sformatf("v%0d l_ready", i), l_ready, vecs[i].e_l_ready);
      check($sformatf("v%0d ld_issue_ready", i), ld_issue_ready, vecs[i].e_ldr);
      check($sformatf("v%0d rs1_busy", i), rs1_busy, vecs[i].e_rs1_busy);
      check($sformatf("v%0d rs2_busy", i), rs2_busy, vecs[i].e_rs2_busy);
      step();
      check($sformatf("v%0d rd_we", i), rd_we, vecs[i].e_we);
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d rd", i), rd, vecs[i].e_rd);
        check($sformatf("v%0d rd_wd", i), rd_wd, vecs[i].e_wd);
      end
    end
    check("regfile r5", reg_model[5], 32'hDEAD_BEEF);
    check("regfile r7", reg_model[7], 32'h2);
    check("regfile r12", reg_model[12], 32'hC);

    // Contention: priority is with A here, so grants go A,L,A,L with a write every cycle.
    drive_idle();
    a_valid = 1'b1; a_rd = 5'd3; a_wd = 32'hAAAA;
    l_valid = 1'b1; l_rd = 5'd4; l_wd = 32'hBBBB;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr%0d a_ready", k), a_ready, (k % 2) == 0);
      check($sformatf("rr%0d l_ready", k), l_ready, (k % 2) == 1);
      step();
      check($sformatf("rr%0d rd_we", k), rd_we, 1'b1);
      check($sformatf("rr%0d rd", k), rd, ((k % 2) == 0) ? 5'd3 : 5'd4);
      check($sformatf("rr%0d rd_wd", k), rd_wd, ((k % 2) == 0) ? 32'hAAAA : 32'hBBBB);
    end

    // Set/clear collision on register 9.
    drive_idle();
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    #1;
    check("col issue1 ready", ld_issue_ready, 1'b1);
    step();
    l_valid = 1'b1; l_rd = 5'd9; l_wd = 32'h99; rs1 = 5'd9;
    #1;
    check("col same_cycle ld_issue_ready", ld_issue_ready, 1'b0);
    check("col same_cycle l_ready", l_ready, 1'b1);
    check("col same_cycle rs1_busy", rs1_busy, 1'b1);
    step();
    l_valid = 1'b0;
    #1;
    check("col return rd_we", rd_we, 1'b1);
    check("col return rd_wd", rd_wd, 32'h99);
    check("col reissue ready", ld_issue_ready, 1'b1);
    check("col cleared rs1_busy", rs1_busy, 1'b0);
    step();
    ld_issue = 1'b0;
    #1;
    check("col reissued rs1_busy", rs1_busy, 1'b1);

    // Retire, then return to a free register while issuing it: the set must survive.
    l_valid = 1'b1; l_wd = 32'h98;
    step();
    l_wd = 32'h97; ld_issue = 1'b1;
    #1;
    check("setwins rs1_busy_before", rs1_busy, 1'b0);
    check("setwins ld_issue_ready", ld_issue_ready, 1'b1);
    check("setwins l_ready", l_ready, 1'b1);
    step();
    drive_idle();
    rs1 = 5'd9;
    #1;
    check("setwins rs1_busy_after", rs1_busy, 1'b1);
    check("setwins rd_wd", rd_wd, 32'h97);
    step();
    check("regfile r9", reg_model[9], 32'h97);
    check("regfile r0", reg_model[0], 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
